// File: rtl/axis_packet_demux.sv
// axis_packet_demux: packet-aware AXI-Stream 1:N demux with a registered FIFO per output
//   clk_i, rst_i          : clock, synchronous active-high reset
//   in_t*                 : input stream (tdata/tkeep/tlast/tid/tdest/tuser, tvalid/tready)
//   en, ctrl              : start permit and destination index, sampled on a packet's first beat
//   out_t*[CHANNEL_NUMBER]: output streams, one FIFO each
//   busy, drop_cnt        : mid-packet flag, saturating count of discarded packets
module axis_packet_demux #(
    parameter int CHANNEL_NUMBER       = 5,
    parameter int CHANNEL_NUMBER_WIDTH = $clog2(CHANNEL_NUMBER + 1),
    parameter int AXIS_DATA_WIDTH      = 40,
    parameter int OUT_DEPTH            = 2,
    parameter int CNT_WIDTH            = 16,
    parameter int ID_WIDTH             = 4,
    parameter int DEST_WIDTH           = 4,
    parameter int USER_WIDTH           = 4
) (
    input  logic                                                 clk_i,
    input  logic                                                 rst_i,
    input  logic [AXIS_DATA_WIDTH-1:0]                           in_tdata,
    input  logic [AXIS_DATA_WIDTH/8-1:0]                         in_tkeep,
    input  logic                                                 in_tlast,
    input  logic [ID_WIDTH-1:0]                                  in_tid,
    input  logic [DEST_WIDTH-1:0]                                in_tdest,
    input  logic [USER_WIDTH-1:0]                                in_tuser,
    input  logic                                                 in_tvalid,
    output logic                                                 in_tready,
    input  logic                                                 en,
    input  logic [CHANNEL_NUMBER_WIDTH-1:0]                      ctrl,
    output logic [CHANNEL_NUMBER-1:0][AXIS_DATA_WIDTH-1:0]       out_tdata,
    output logic [CHANNEL_NUMBER-1:0][AXIS_DATA_WIDTH/8-1:0]     out_tkeep,
    output logic [CHANNEL_NUMBER-1:0]                            out_tlast,
    output logic [CHANNEL_NUMBER-1:0][ID_WIDTH-1:0]              out_tid,
    output logic [CHANNEL_NUMBER-1:0][DEST_WIDTH-1:0]            out_tdest,
    output logic [CHANNEL_NUMBER-1:0][USER_WIDTH-1:0]            out_tuser,
    output logic [CHANNEL_NUMBER-1:0]                            out_tvalid,
    input  logic [CHANNEL_NUMBER-1:0]                            out_tready,
    output logic                                                 busy,
    output logic [CNT_WIDTH-1:0]                                 drop_cnt
);
    localparam int N  = CHANNEL_NUMBER;
    localparam int CW = CHANNEL_NUMBER_WIDTH;
    localparam int AW = $clog2(OUT_DEPTH);
    localparam int EW = AXIS_DATA_WIDTH + AXIS_DATA_WIDTH/8 + 1 + ID_WIDTH + DEST_WIDTH + USER_WIDTH;

    typedef enum logic [1:0] {IDLE, ROUTE, DROP} state_t;

    state_t          state, state_n;
    logic [CW-1:0]   sel, dest;
    // one full flag per encodable index; nonexistent channels read as never full,
    // so an invalid destination is always ready and can be discarded
    logic [2**CW-1:0] full;
    logic [N-1:0]    push, pop;
    logic            ctrl_ok, accept, drop_inc;
    logic [EW-1:0]   din;

    assign ctrl_ok   = ctrl < CW'(N);
    assign dest      = state == IDLE ? ctrl : sel;
    assign in_tready = !rst_i && (state == IDLE ? en && !full[ctrl] : state == ROUTE ? !full[sel] : 1'b1);
    assign accept    = in_tvalid && in_tready;
    assign busy      = state != IDLE;
    assign din       = {in_tuser, in_tdest, in_tid, in_tkeep, in_tlast, in_tdata};

    always_comb begin
        state_n  = state;
        drop_inc = 1'b0;
        if (accept && state == IDLE) begin
            state_n  = in_tlast ? IDLE : ctrl_ok ? ROUTE : DROP;
            drop_inc = in_tlast && !ctrl_ok;
        end else if (accept && in_tlast) begin
            state_n  = IDLE;
            drop_inc = state == DROP;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            sel      <= '0;
            drop_cnt <= '0;
        end else begin
            state <= state_n;
            if (accept && state == IDLE) sel <= ctrl;
            if (drop_inc && !(&drop_cnt)) drop_cnt <= drop_cnt + CNT_WIDTH'(1);
        end
    end

    for (genvar c = 0; c < 2**CW; c++) begin : g_ch
        if (c < N) begin : g_fifo
            logic [EW-1:0] mem [OUT_DEPTH];
            logic [AW-1:0] wr, rd;
            logic [AW:0]   cnt;
            assign full[c]       = cnt == (AW+1)'(OUT_DEPTH);
            assign push[c]       = accept && state != DROP && dest == CW'(c);
            assign pop[c]        = out_tvalid[c] && out_tready[c];
            assign out_tvalid[c] = cnt != '0;
            assign {out_tuser[c], out_tdest[c], out_tid[c], out_tkeep[c], out_tlast[c], out_tdata[c]} = mem[rd];
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    wr  <= '0;
                    rd  <= '0;
                    cnt <= '0;
                    for (int k = 0; k < OUT_DEPTH; k++) mem[k] <= '0;
                end else begin
                    if (push[c]) mem[wr] <= din;
                    if (push[c]) wr <= wr + AW'(1);
                    if (pop[c]) rd <= rd + AW'(1);
                    cnt <= cnt + (AW+1)'(push[c]) - (AW+1)'(pop[c]);
                end
            end
        end else begin : g_none
            assign full[c] = 1'b0;
        end
    end
endmodule

// File: tb/tb_axis_packet_demux.sv
// tb_axis_packet_demux: directed stimulus with per-channel expected queues and a decoupled output monitor
module tb_axis_packet_demux;
    localparam int N  = 5;
    localparam int W  = 40;
    localparam int EW = 58;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [W-1:0]          in_tdata;
    logic [4:0]            in_tkeep;
    logic                  in_tlast, in_tvalid, in_tready, en, busy;
    logic [3:0]            in_tid, in_tdest, in_tuser;
    logic [2:0]            ctrl;
    logic [N-1:0][W-1:0]   out_tdata;
    logic [N-1:0][4:0]     out_tkeep;
    logic [N-1:0]          out_tlast, out_tvalid, out_tready;
    logic [N-1:0][3:0]     out_tid, out_tdest, out_tuser;
    logic [1:0]            drop_cnt;

    axis_packet_demux #(.CNT_WIDTH(2)) dut (
        .clk_i(clk), .rst_i(rst),
        .in_tdata(in_tdata), .in_tkeep(in_tkeep), .in_tlast(in_tlast), .in_tid(in_tid),
        .in_tdest(in_tdest), .in_tuser(in_tuser), .in_tvalid(in_tvalid), .in_tready(in_tready),
        .en(en), .ctrl(ctrl),
        .out_tdata(out_tdata), .out_tkeep(out_tkeep), .out_tlast(out_tlast), .out_tid(out_tid),
        .out_tdest(out_tdest), .out_tuser(out_tuser), .out_tvalid(out_tvalid), .out_tready(out_tready),
        .busy(busy), .drop_cnt(drop_cnt)
    );

    int tests = 0;
    int fails = 0;
    logic [EW-1:0] q [N][$];

    function automatic logic [EW-1:0] ent(input logic [W-1:0] d, input logic l);
        return {d[11:8], d[7:4], d[3:0], 5'h1f, l, d};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [W-1:0] d, input logic l, input logic [2:0] c, input logic e);
        in_tdata  = d;
        in_tkeep  = 5'h1f;
        in_tid    = d[3:0];
        in_tdest  = d[7:4];
        in_tuser  = d[11:8];
        in_tlast  = l;
        ctrl      = c;
        en        = e;
        in_tvalid = 1'b1;
    endtask

    // ch < 0 means the beat is expected to be discarded
    task automatic send(input logic [W-1:0] d, input logic l, input logic [2:0] c, input logic e,
                        input int ch, output int waits);
        drive(d, l, c, e);
        waits = 0;
        @(negedge clk);
        while (!in_tready && waits < 100) begin
            waits++;
            @(negedge clk);
        end
        if (!in_tready) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: beat %0h never accepted, ready=%0b required 1", d, in_tready);
        end else if (ch >= 0) q[ch].push_back(ent(d, l));
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin : monitor
        logic [EW-1:0] a, e;
        if (!rst) for (int i = 0; i < N; i++) if (out_tvalid[i] && out_tready[i]) begin
            a = {out_tuser[i], out_tdest[i], out_tid[i], out_tkeep[i], out_tlast[i], out_tdata[i]};
            tests++;
            if (q[i].size() == 0) begin
                fails++;
                $display("FAIL ch%0d_unexpected: got %0h required none", i, a);
            end else begin
                e = q[i].pop_front();
                if (a !== e) begin
                    fails++;
                    $display("FAIL ch%0d_beat: got %0h required %0h", i, a, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int chs [4] = '{0, 1, 0, 3};
        out_tready = '1;
        drive(40'h0, 1'b0, 3'd0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        check("rst_tready", in_tready, 0);
        check("rst_tvalid", out_tvalid, 0);
        check("rst_busy", busy, 0);
        check("rst_drop_cnt", drop_cnt, 0);
        check("rst_payload", out_tdata[0], 0);
        in_tvalid = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 4-beat packet locked to ch2 while ctrl moves to 0
        send(40'hA1_0000_0321, 1'b0, 3'd2, 1'b1, 2, w);
        check("t1_busy_b0", busy, 1);
        check("t1_latency_valid", out_tvalid[2], 1);
        check("t1_latency_data", out_tdata[2], 40'hA1_0000_0321);
        send(40'hA2_0000_0432, 1'b0, 3'd0, 1'b1, 2, w);
        send(40'hA3_0000_0543, 1'b0, 3'd0, 1'b1, 2, w);
        check("t1_busy_b2", busy, 1);
        send(40'hA4_0000_0654, 1'b1, 3'd0, 1'b1, 2, w);
        check("t1_busy_end", busy, 0);

        // 3-beat drop, then single-beat drops up to saturation (CNT_WIDTH=2)
        send(40'hB1_0000_0111, 1'b0, 3'd7, 1'b1, -1, w);
        check("t2_ready_b0", w, 0);
        check("t2_busy", busy, 1);
        send(40'hB2_0000_0222, 1'b0, 3'd0, 1'b1, -1, w);
        check("t2_ready_b1", w, 0);
        check("t2_cnt_mid", drop_cnt, 0);
        send(40'hB3_0000_0333, 1'b1, 3'd0, 1'b1, -1, w);
        check("t2_ready_b2", w, 0);
        check("t2_cnt_1", drop_cnt, 1);
        check("t2_no_valid", out_tvalid, 0);
        send(40'hB4_0000_0444, 1'b1, 3'd5, 1'b1, -1, w);
        check("t2_cnt_2", drop_cnt, 2);
        send(40'hB5_0000_0555, 1'b1, 3'd6, 1'b1, -1, w);
        check("t2_cnt_3", drop_cnt, 3);
        send(40'hB6_0000_0666, 1'b1, 3'd7, 1'b1, -1, w);
        check("t2_cnt_sat", drop_cnt, 3);

        // backpressure on ch1: two beats fill the FIFO, then the input stalls
        out_tready[1] = 1'b0;
        send(40'hC1_0000_0712, 1'b0, 3'd1, 1'b1, 1, w);
        send(40'hC2_0000_0823, 1'b0, 3'd0, 1'b1, 1, w);
        drive(40'hC3_0000_0934, 1'b0, 3'd0, 1'b1);
        @(negedge clk);
        check("t3_stall_a", in_tready, 0);
        @(negedge clk);
        check("t3_stall_b", in_tready, 0);
        check("t3_held_valid", out_tvalid[1], 1);
        @(posedge clk);
        #1;
        out_tready[1] = 1'b1;
        send(40'hC3_0000_0934, 1'b0, 3'd0, 1'b1, 1, w);
        send(40'hC4_0000_0a45, 1'b0, 3'd0, 1'b1, 1, w);
        send(40'hC5_0000_0b56, 1'b1, 3'd0, 1'b1, 1, w);

        // back-to-back single-beat packets
        for (int i = 0; i < 4; i++) begin
            send(40'hD0_0000_0c00 + 40'(i), 1'b1, 3'(chs[i]), 1'b1, chs[i], w);
            check("t4_no_wait", w, 0);
            check("t4_idle", busy, 0);
        end

        // en=0 blocks a packet start; dropping en mid-packet does not
        drive(40'hE0_0000_0d67, 1'b0, 3'd1, 1'b0);
        repeat (3) begin
            @(negedge clk);
            check("t5_en_low_ready", in_tready, 0);
        end
        check("t5_en_low_valid", out_tvalid, 0);
        @(posedge clk);
        #1;
        send(40'hE0_0000_0d67, 1'b0, 3'd1, 1'b1, 1, w);
        send(40'hE1_0000_0e78, 1'b0, 3'd4, 1'b0, 1, w);
        send(40'hE2_0000_0f89, 1'b1, 3'd4, 1'b0, 1, w);
        check("t5_done_idle", busy, 0);

        // reset mid-packet to ch3 with its sink stalled
        out_tready[3] = 1'b0;
        send(40'hF0_0000_0193, 1'b0, 3'd3, 1'b1, 3, w);
        send(40'hF1_0000_02a3, 1'b0, 3'd3, 1'b1, 3, w);
        drive(40'hF2_0000_03b1, 1'b1, 3'd1, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check("t6_rst_ready", in_tready, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        q[3].delete();
        check("t6_rst_tvalid", out_tvalid, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_cnt", drop_cnt, 0);
        out_tready[3] = 1'b1;
        send(40'hF2_0000_03b1, 1'b1, 3'd1, 1'b1, 1, w);
        check("t6_new_pkt_idle", busy, 0);

        in_tvalid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) check($sformatf("drain_ch%0d", i), q[i].size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/axis_packet_demux.md
Name: axis_packet_demux

Overview:
Packet-aware AXI-Stream 1:N demultiplexer with a registered per-output buffer. The route is sampled from ctrl on the first beat of each packet and held until the TLAST beat, so a packet is never split across channels. Packets addressed to a non-existent channel are accepted and discarded, and counted. It sits between an AXIS source (router input stage / PMU stream) and N downstream AXIS consumers.

Parameters:
CHANNEL_NUMBER, 5, number of output channels (>=2)
CHANNEL_NUMBER_WIDTH, $clog2(CHANNEL_NUMBER+1), ctrl width; wide enough to encode invalid indices
AXIS_DATA_WIDTH, 40, TDATA width
OUT_DEPTH, 2, entries per output FIFO; power of two, >=2
CNT_WIDTH, 16, width of drop_cnt
ID_WIDTH, 4, TID width (only when TID_PRESENT)
DEST_WIDTH, 4, TDEST width (only when TDEST_PRESENT)
USER_WIDTH, 4, TUSER width (only when TUSER_PRESENT)

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; synchronous, active-high
in  axis_if.s  -  input stream; optional sidebands per the TSTRB/TKEEP/TLAST/TID/TDEST/TUSER defines
en  in  1  permits the start of a new packet
ctrl  in  CHANNEL_NUMBER_WIDTH  destination index; sampled only on a packet's first beat
out[CHANNEL_NUMBER]  axis_if.m  -  output streams
busy  out  1  high while mid-packet (ROUTE or DROP)
drop_cnt  out  CNT_WIDTH  saturating count of discarded packets

Behaviour:
- Reset (rst_i=1 at a clk_i edge): state=IDLE; all FIFOs emptied; every out[i].TVALID=0; out payloads=0; in.TREADY=0 while rst_i is high; busy=0; drop_cnt=0. A reset mid-packet abandons the packet, and the remainder is treated as new traffic.
- States:
  - IDLE: waiting for a first beat.
  - ROUTE: mid-packet to the locked channel sel.
  - DROP: mid-packet discard.
- Effective destination: in IDLE, ctrl (combinational). In ROUTE, the registered sel.
- in.TREADY:
  - IDLE with en=0: 0.
  - IDLE with en=1 and ctrl<CHANNEL_NUMBER: !full[ctrl].
  - IDLE with en=1 and ctrl>=CHANNEL_NUMBER: 1.
  - ROUTE: !full[sel].
  - DROP: 1.
- A beat is accepted when in.TVALID && in.TREADY. An accepted routed beat is written into FIFO[dest] with all present sideband fields.
- Transitions, on an accepted beat:
  - IDLE to ROUTE: valid dest and TLAST=0; latch sel=ctrl.
  - IDLE to DROP: invalid dest and TLAST=0.
  - IDLE stays IDLE: TLAST=1 (single-beat packet).
  - ROUTE or DROP to IDLE: on the accepted TLAST beat.
- en and ctrl are ignored outside IDLE. When TLAST_PRESENT is undefined, every beat counts as TLAST=1 (per-beat routing).
- drop_cnt increments by 1 on the accepted TLAST beat of a dropped packet, including a single-beat drop. It saturates at all-ones.
- Output FIFO i:
  - out[i].TVALID = !empty; payload is the head entry.
  - Pop on out[i].TVALID && out[i].TREADY.
  - Simultaneous push and pop when full is not allowed, because TREADY already reflects full. Simultaneous push and pop at other occupancies keeps the count unchanged.
  - Pointers wrap modulo OUT_DEPTH. The count is $clog2(OUT_DEPTH)+1 bits.
- Latency: a beat accepted at edge k is visible on out at edge k (registered) and can be consumed on edge k+1. Minimum latency is 1 cycle. Sustained throughput is 1 beat/cycle with OUT_DEPTH>=2 and a ready sink.
- Channels drain independently. A stalled channel blocks input only while it is the effective destination.
- busy = (state != IDLE).
- Outputs are never X after reset. Payload of empty FIFOs is don't-care but driven as 0 at reset.

Test Plan:
- 4-beat packet, ctrl=2 on beat 0, ctrl changed to 0 on beats 1-3, all sinks ready -> all 4 beats on out[2] in order, 1-cycle latency; busy high from after beat 0 until after beat 3; out[0] TVALID stays 0.
- 3-beat packet with ctrl=7 (CHANNEL_NUMBER=5) -> in.TREADY=1 for all 3 beats; no out TVALID; drop_cnt 0->1 on the TLAST beat. Force drop_cnt to all-ones -> a further drop leaves it at all-ones.
- out[1].TREADY=0, OUT_DEPTH=2, 5-beat packet to ch1 -> 2 beats accepted, then in.TREADY=0. Release TREADY -> remaining 3 beats flow, no loss, order kept.
- Back-to-back single-beat packets with ctrl=0,1,0,3, en=1 -> one beat per cycle; each appears once on its channel; state stays IDLE.
- en=0 with in.TVALID=1 -> in.TREADY=0, nothing accepted. Then en dropped mid-packet -> the packet still completes.
- rst_i asserted after beat 1 of a 4-beat packet to ch3 -> next cycle: FIFOs empty, all TVALID=0, busy=0. The following beat is treated as a new packet using the current ctrl.
